// File: rtl/blk_frame_gate.sv
// blk_frame_gate: block-granular admission FIFO; drops the rest of a frame when a whole block cannot be reserved.
// Optional BLK_GATE_STATS_EN implements the saturating frames_dropped counter.
module blk_frame_gate #(
  parameter int N           = 2,
  parameter int FIFO_BLOCKS = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [N*8-1:0]                     in_data_y,
  input  logic [N*8-1:0]                     in_data_cr,
  input  logic [N*8-1:0]                     in_data_cb,
  input  logic                               in_sob,
  input  logic                               in_eob,
  input  logic                               in_sof,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N*8-1:0]                     out_data_y,
  output logic [N*8-1:0]                     out_data_cr,
  output logic [N*8-1:0]                     out_data_cb,
  output logic                               out_sob,
  output logic                               out_eob,
  output logic                               out_sof,
  output logic                               out_trunc,
  output logic                               frame_dropped,
  output logic [15:0]                        frames_dropped,
  output logic [$clog2(FIFO_BLOCKS+1)-1:0]   blk_alloc
);
  localparam int W  = 64 / N;
  localparam int D  = FIFO_BLOCKS * W;
  localparam int DW = 24 * N + 4;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam int AW = $clog2(FIFO_BLOCKS + 1);
  localparam logic [AW-1:0] FB = AW'(FIFO_BLOCKS);

  typedef enum logic [1:0] {WAIT_SOF, PASS, DROP} state_t;

  state_t state, state_nx;
  logic space, v_sob, v_sof, wr, admit, drop, set_trunc, pop, rel, pend_trunc;
  logic [DW-1:0] mem [D];
  logic [DW-1:0] wr_word, out_word;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  assign space   = blk_alloc < FB;
  assign v_sob   = in_valid & in_sob;
  assign v_sof   = in_valid & in_sof;
  assign rel     = out_valid & out_ready & out_eob;
  assign pop     = (cnt != '0) & (~out_valid | out_ready);
  assign wr_word = {in_sof & pend_trunc, in_sof, in_eob, in_sob, in_data_cb, in_data_cr, in_data_y};
  assign {out_trunc, out_sof, out_eob, out_sob, out_data_cb, out_data_cr, out_data_y} = out_word;

  always_comb begin
    state_nx  = state;
    wr        = 1'b0;
    admit     = 1'b0;
    drop      = 1'b0;
    set_trunc = 1'b0;
    case (state)
      WAIT_SOF, DROP: if (v_sof) begin
        wr       = space;
        admit    = space;
        drop     = ~space;
        state_nx = space ? PASS : DROP;
      end
      PASS: if (v_sob && !space) begin
        drop      = 1'b1;
        set_trunc = ~in_sof;
        state_nx  = DROP;
      end else begin
        wr    = in_valid;
        admit = v_sob;
      end
      default: state_nx = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_SOF;
      pend_trunc    <= 1'b0;
      frame_dropped <= 1'b0;
      blk_alloc     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_word      <= '0;
    end else begin
      state         <= state_nx;
      pend_trunc    <= set_trunc ? 1'b1 : (wr & in_sof) ? 1'b0 : pend_trunc;
      frame_dropped <= drop;
      blk_alloc     <= blk_alloc + AW'(admit) - AW'(rel);
      wr_ptr        <= wr ? (wr_ptr == PW'(D - 1) ? '0 : wr_ptr + PW'(1)) : wr_ptr;
      rd_ptr        <= pop ? (rd_ptr == PW'(D - 1) ? '0 : rd_ptr + PW'(1)) : rd_ptr;
      cnt           <= cnt + CW'(wr) - CW'(pop);
      out_valid     <= pop | (out_valid & ~out_ready);
      out_word      <= pop ? mem[rd_ptr] : out_word;
    end
  end

  // Storage is not reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_word;
  end

`ifdef BLK_GATE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frames_dropped <= '0;
    else if (drop && frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
  end
`else
  assign frames_dropped = '0;
`endif
endmodule

// File: tb/tb_blk_frame_gate.sv
// tb_blk_frame_gate: directed self-checking bench for blk_frame_gate (N=2, FIFO_BLOCKS=4).
module tb_blk_frame_gate;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int DW = 24 * N + 4;
`ifdef BLK_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data_y = '0, in_data_cr = '0, in_data_cb = '0;
  logic out_valid, out_sob, out_eob, out_sof, out_trunc, frame_dropped;
  logic [15:0] out_data_y, out_data_cr, out_data_cb, frames_dropped;
  logic [2:0] blk_alloc;
  logic [DW-1:0] ow, prev;
  logic [DW-1:0] q [$];
  int tests = 0, fails = 0, seq = 0, n;
  bit hold = 1'b0, stop;

  blk_frame_gate #(.N(N), .FIFO_BLOCKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data_y(in_data_y), .in_data_cr(in_data_cr), .in_data_cb(in_data_cb),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_y(out_data_y), .out_data_cr(out_data_cr), .out_data_cb(out_data_cb),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof), .out_trunc(out_trunc),
    .frame_dropped(frame_dropped), .frames_dropped(frames_dropped), .blk_alloc(blk_alloc)
  );

  always #5 clk = ~clk;
  assign ow = {out_trunc, out_sof, out_eob, out_sob, out_data_cb, out_data_cr, out_data_y};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshaken word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold) check("stable", 64'(ow), 64'(prev));
      hold = out_valid && !out_ready;
      prev = ow;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_word", 64'(q.size()), 64'd1);
        else check("word", 64'(ow), 64'(q.pop_front()));
      end
    end else hold = 1'b0;
  end

  task automatic put(bit sob, bit eob, bit sof, bit keep, bit tr);
    logic [15:0] s;
    s = seq[15:0];
    in_valid = 1'b1; in_sob = sob; in_eob = eob; in_sof = sof;
    in_data_y = s; in_data_cr = ~s; in_data_cb = s ^ 16'h5a3c;
    if (keep) q.push_back({tr & sof, sof, eob, sob, s ^ 16'h5a3c, ~s, s});
    seq++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
  endtask

  task automatic block(bit sof, bit keep, bit tr, int first);
    for (int i = first; i < W; i++) put(i == 0, i == W - 1, sof && i == 0, keep, tr);
  endtask

  task automatic drain(string tag);
    int k = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_left"}, 64'(q.size()), 64'd0);
    check({tag, "_alloc"}, 64'(blk_alloc), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_word", 64'(ow), 64'd0);
    check("rst_alloc", 64'(blk_alloc), 64'd0);
    check("rst_pulse", 64'(frame_dropped), 64'd0);
    check("rst_count", 64'(frames_dropped), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Three-block frame, latency of the first word, ordering and markers.
    out_ready = 1'b1;
    put(1, 0, 1, 1, 0);
    @(negedge clk); check("lat_t1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_t2", 64'(out_valid), 64'd1);
    block(1, 1, 0, 1);
    block(0, 1, 0, 0);
    block(0, 1, 0, 0);
    drain("t1");
    check("t1_count", 64'(frames_dropped), 64'd0);

    // Mid-frame reset flushes; pre-SOF blocks never appear.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) put(i == 0, 0, i == 0, 0, 0);
    repeat (3) @(negedge clk);
    check("t2_held", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t2_flush", 64'(out_valid), 64'd0);
    check("t2_alloc0", 64'(blk_alloc), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    block(0, 0, 0, 0);
    block(0, 0, 0, 0);
    block(1, 1, 0, 0);
    drain("t2");

    // Overflow with stalled output: truncation of the fifth block.
    out_ready = 1'b0;
    block(1, 1, 0, 0);
    for (int b = 0; b < 3; b++) block(0, 1, 0, 0);
    put(1, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_pulse", 64'(frame_dropped), 64'd1);
    check("t3_alloc", 64'(blk_alloc), 64'd4);
    block(0, 0, 0, 1);
    @(negedge clk);
    check("t3_pulse_end", 64'(frame_dropped), 64'd0);
    block(0, 0, 0, 0);
    drain("t3");
    check("t3_count", 64'(frames_dropped), 64'(STATS));
    block(1, 1, 1, 0);
    drain("t3b");

    // Release on out_eob in the same cycle as an input SOB with the FIFO full.
    out_ready = 1'b0;
    block(1, 1, 0, 0);
    for (int b = 0; b < 3; b++) block(0, 1, 0, 0);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_eob) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_bound", 64'(n < 100), 64'd1);
    in_valid = 1'b1; in_sob = 1'b1;
    in_data_y = seq[15:0]; in_data_cr = ~seq[15:0]; in_data_cb = seq[15:0];
    seq++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sob = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("t4_pulse", 64'(frame_dropped), 64'd1);
    check("t4_alloc", 64'(blk_alloc), 64'd3);
    block(0, 0, 0, 1);
    drain("t4");
    check("t4_count", 64'(frames_dropped), 64'(2 * STATS));
    block(1, 1, 1, 0);
    drain("t4b");

    // Random 1-5 cycle stalls: bit-exact data, stable outputs, no drops.
    stop = 1'b0;
    fork
      begin
        block(1, 1, 0, 0);
        block(0, 1, 0, 0);
        stop = 1'b1;
      end
      while (!stop) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    join
    drain("t5");
    check("t5_count", 64'(frames_dropped), 64'(2 * STATS));

    // Repeated frames dropped at SOF: counter saturation, no trunc flag.
    out_ready = 1'b0;
    block(1, 1, 0, 0);
    for (int b = 0; b < 3; b++) block(0, 1, 0, 0);
`ifdef BLK_GATE_STATS_EN
    for (int i = 0; i < 65536; i++) put(1, 0, 1, 0, 0);
    @(negedge clk);
    check("t6_sat", 64'(frames_dropped), 64'hFFFF);
    put(1, 0, 1, 0, 0);
    @(negedge clk);
    check("t6_sat_hold", 64'(frames_dropped), 64'hFFFF);
`else
    for (int i = 0; i < 4; i++) put(1, 0, 1, 0, 0);
    @(negedge clk);
    check("t6_zero", 64'(frames_dropped), 64'd0);
`endif
    check("t6_pulse", 64'(frame_dropped), 64'd1);
    drain("t6");
    block(1, 1, 0, 0);
    drain("t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
